// File: rtl/tx_arb_pkg.sv
// Shared types, widths and helpers for the tx_raw frame arbiter.
package tx_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      DRAIN = 2'd2,
      GAP   = 2'd3
   } state_t;

   localparam int GRANT_W    = 3;
   localparam int WORD_CNT_W = 12;

   // Add and clamp at 0xFFFF so statistics stick at full scale instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] val, input logic [15:0] inc);
      logic [16:0] sum;
      sum = {1'b0, val} + {1'b0, inc};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first candidate at or after ptr, wrapping modulo N.
// Purely combinational; no backpressure.
module rr_pick
   import tx_arb_pkg::*;
#(
   parameter int N = 3
) (
   input  logic [N-1:0]       cand,
   input  logic [GRANT_W-1:0] ptr,
   output logic [N-1:0]       onehot,
   output logic [GRANT_W-1:0] idx
);

   logic found;

   always_comb begin
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      for (int k = 0; k < N; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!found && cand[i] && (i == (int'(ptr) + k) % N)) begin
               found     = 1'b1;
               onehot[i] = 1'b1;
               idx       = GRANT_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Whole-frame arbiter sharing the tx_raw write port; truncates frames at MAX_WORDS and keeps statistics.
// Grant 1 cycle after sof in IDLE, then 0-latency pass-through; tx_stop combinationally stalls src_ready/tx_we.
// TX_ARB_STRICT_PRIO_EN: source 0 wins whenever it requests, others stay round-robin.
module tx_frame_arbiter
   import tx_arb_pkg::*;
#(
   parameter int N_SRC      = 3,
   parameter int MAX_WORDS  = 2250,
   parameter int GAP_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [32*N_SRC-1:0]   src_data,
   input  logic [N_SRC-1:0]      src_sof,
   input  logic [N_SRC-1:0]      src_last,
   input  logic [N_SRC-1:0]      src_valid,
   output logic [N_SRC-1:0]      src_ready,
   output logic [31:0]           tx_data,
   output logic                  tx_sof,
   output logic                  tx_we,
   input  logic                  tx_stop,
   output logic [GRANT_W-1:0]    grant_id,
   output logic                  busy,
   output logic [31:0]           frame_count,
   output logic [15:0]           trunc_count,
   output logic [15:0]           orphan_count
);

   localparam logic [WORD_CNT_W-1:0] LAST_CNT  = WORD_CNT_W'(MAX_WORDS - 1);
   localparam logic [15:0]           GAP_LAST  = 16'(GAP_CYCLES - 1);
   localparam state_t                END_STATE = (GAP_CYCLES > 0) ? GAP : IDLE;

   state_t                 state, state_nxt;
   logic [GRANT_W-1:0]     rr_ptr, rr_next;
   logic [WORD_CNT_W-1:0]  word_cnt;
   logic [15:0]            gap_cnt;

   logic [N_SRC-1:0]       cand, pick_cand, pick_onehot, orphan_vec, gnt_1h;
   logic [GRANT_W-1:0]     pick_idx;
   logic                   pick_any;
   logic [15:0]            orphan_n;

   logic [31:0]            sel_data;
   logic                   sel_valid, sel_sof, sel_last;
   logic                   xfer_we, frame_end, trunc, drain_end, gap_done;

   assign cand       = src_valid & src_sof;
   assign orphan_vec = src_valid & ~src_sof;

`ifdef TX_ARB_STRICT_PRIO_EN
   assign pick_cand = cand[0] ? {{(N_SRC-1){1'b0}}, 1'b1} : cand;
`else
   assign pick_cand = cand;
`endif

   rr_pick #(.N(N_SRC)) u_pick (
      .cand   (pick_cand),
      .ptr    (rr_ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx)
   );

   assign pick_any = |pick_onehot;

   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      sel_sof   = 1'b0;
      sel_last  = 1'b0;
      gnt_1h    = '0;
      orphan_n  = '0;
      for (int i = 0; i < N_SRC; i++) begin
         orphan_n = orphan_n + 16'(orphan_vec[i]);
         if (grant_id == GRANT_W'(i)) begin
            gnt_1h[i] = 1'b1;
            sel_data  = src_data[32*i +: 32];
            sel_valid = src_valid[i];
            sel_sof   = src_sof[i];
            sel_last  = src_last[i];
         end
      end
   end

   assign xfer_we   = (state == XFER) && sel_valid && !tx_stop;
   assign frame_end = xfer_we && sel_last;
   // The MAX_WORDS-th word still goes out; only what follows it is discarded.
   assign trunc     = xfer_we && !sel_last && (word_cnt == LAST_CNT);
   assign drain_end = (state == DRAIN) && sel_valid && sel_last;
   assign gap_done  = (state == GAP) && (gap_cnt == GAP_LAST);
   assign rr_next   = (grant_id == GRANT_W'(N_SRC - 1)) ? '0 : grant_id + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_any)  state_nxt = XFER;
         XFER:    if (frame_end) state_nxt = END_STATE;
                  else if (trunc) state_nxt = DRAIN;
         DRAIN:   if (drain_end) state_nxt = END_STATE;
         GAP:     if (gap_done)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      src_ready = '0;
      tx_we     = 1'b0;
      tx_sof    = 1'b0;
      tx_data   = sel_data;
      busy      = (state == XFER) || (state == DRAIN);
      if (!reset) begin
         case (state)
            IDLE:  src_ready = orphan_vec;
            XFER: begin
               src_ready = gnt_1h & {N_SRC{~tx_stop}};
               tx_we     = xfer_we;
               tx_sof    = sel_sof && (word_cnt == '0);
            end
            DRAIN: src_ready = gnt_1h;
            default: src_ready = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         grant_id     <= '0;
         rr_ptr       <= '0;
         word_cnt     <= '0;
         gap_cnt      <= '0;
         frame_count  <= '0;
         trunc_count  <= '0;
         orphan_count <= '0;
      end else begin
         if (state == IDLE) begin
            orphan_count <= sat_inc16(orphan_count, orphan_n);
            if (pick_any) begin
               grant_id <= pick_idx;
               word_cnt <= '0;
            end
         end
         if (xfer_we)               word_cnt    <= word_cnt + 1'b1;
         if (frame_end)             frame_count <= frame_count + 1'b1;
         if (frame_end || drain_end) rr_ptr     <= rr_next;
         if (trunc)                 trunc_count <= sat_inc16(trunc_count, 16'd1);
         if (state == GAP)          gap_cnt     <= gap_cnt + 1'b1;
         else                       gap_cnt     <= '0;
      end
   end

endmodule

// File: doc/tx_frame_arbiter.md
Name: tx_frame_arbiter

Overview:
- Shares the single tx_raw user-side write port (tx_data/tx_sof/tx_we/tx_stop) among N frame sources, e.g. video packetizer, ARP/ICMP responder and control-reply UDP.
- Grants whole frames only: a granted source owns the port from its sof word through its last word. Arbitration is round-robin.
- Sits in the usr_clk domain directly in front of tx_raw. Also enforces a per-frame word limit and keeps frame/error statistics.

Parameters:
- N_SRC, 3, number of requesters (2..8).
- MAX_WORDS, 2250, maximum 32-bit words per frame (9000-byte jumbo); frames reaching it are truncated.
- GAP_CYCLES, 1, idle cycles inserted between released grant and next grant.

Ports:
- clk  in  1  usr_clk domain clock.
- reset  in  1  synchronous, active-high reset.
- src_data  in  32*N_SRC  word per source, source i at bits [32i+31:32i].
- src_sof  in  N_SRC  first word of frame.
- src_last  in  N_SRC  final word of frame.
- src_valid  in  N_SRC  word present.
- src_ready  out  N_SRC  word accepted this cycle when valid&ready.
- tx_data  out  32  to tx_raw.
- tx_sof  out  1  to tx_raw.
- tx_we  out  1  to tx_raw.
- tx_stop  in  1  tx_raw FIFO full.
- grant_id  out  3  current owner index, valid when busy.
- busy  out  1  a frame is in progress.
- frame_count  out  32  frames completed, wraps.
- trunc_count  out  16  frames truncated at MAX_WORDS, saturates at 0xFFFF.
- orphan_count  out  16  words discarded (valid without grant and without sof), saturates.

Behaviour:
- Reset: state IDLE, busy=0, grant_id=0, rr pointer=0, all counters=0, src_ready=0, tx_we=0.
- States: IDLE, XFER, DRAIN, GAP.
- IDLE: candidates = src_valid & src_sof. Choose the first candidate at or after rr pointer (wrapping modulo N_SRC). Register grant_id, set busy, go XFER next cycle. No word moves in the grant cycle.
- IDLE orphan handling: a source with src_valid=1 and src_sof=0 gets src_ready=1 for one cycle. The word is dropped and orphan_count increments by 1; each such source counts once per cycle.
- XFER datapath (combinational from registered grant):
  - src_ready[g] = ~tx_stop; all other src_ready bits = 0.
  - tx_we = src_valid[g] & ~tx_stop.
  - tx_data = src_data[g]; tx_sof = src_sof[g] & (word_cnt==0).
- XFER word counter: 12 bits, increments on each tx_we.
- Normal end: on a tx_we with src_last[g], frame_count++, rr pointer = g+1 mod N_SRC, then go to GAP (GAP_CYCLES>0) or IDLE.
- Truncation: if word_cnt reaches MAX_WORDS-1 on a tx_we without src_last, that word is written with no special marking, trunc_count++, and the state goes to DRAIN.
- DRAIN: src_ready[g]=1 and tx_we=0. Words from g are discarded until src_last[g] is accepted, then the state goes to GAP/IDLE. frame_count does not increment.
- sof seen mid-frame from g (word_cnt>0): the word is passed with tx_sof=0. No error is flagged; tx_raw framing is the source's responsibility.
- tx_stop asserted: zero transfers occur; state and counters hold. Combinational path tx_stop -> src_ready/tx_we is allowed.
- GAP: counts GAP_CYCLES with all ready=0, then goes to IDLE. busy=0 in IDLE and GAP.
- Reset mid-frame: returns to IDLE immediately. A partially written frame remains in tx_raw; the system resets tx_raw together with this block.
- Latency: grant is 1 cycle after a sof is presented in IDLE. Thereafter 1 word/cycle, zero-latency pass-through.

Optional Feature:
- TX_ARB_STRICT_PRIO_EN defined: source 0 wins any IDLE arbitration in which it is a candidate; the other sources are round-robin among themselves.
- Undefined: pure round-robin across all N_SRC. Port list is identical in both cases.

Decomposition:
- Package tx_arb_pkg: state enum (IDLE, XFER, DRAIN, GAP), GRANT_W=3, WORD_CNT_W=12, and the saturate-increment function used by trunc_count and orphan_count.
- One sub-module, rr_pick: combinational N_SRC-wide rotating priority picker (candidates, pointer -> one-hot and index).

Test Plan:
- Sources 0 and 2 both raise sof in the same cycle, rr=0 -> grant 0. After its 4-word frame, grant 2 follows; frame_count=2, and tx_sof is asserted exactly twice.
- All 3 sources stream back-to-back 2-word frames -> grant order 0,1,2,0,1,2, with GAP_CYCLES idle cycles between frames.
- tx_stop held for 5 cycles mid-frame -> tx_we=0 and src_ready=0 for those cycles; the word sequence out of tx_raw is unchanged and has no duplicates.
- MAX_WORDS=8, source sends a 12-word frame -> 8 words written, 4 drained, trunc_count=1, frame_count=0, next frame granted normally.
- Source 1 presents 3 words with sof=0 while IDLE -> all 3 are dropped, orphan_count=3, tx_we never asserted.
- TX_ARB_STRICT_PRIO_EN defined, rr=1, sources 0 and 1 both request -> source 0 granted first.
